spi_arbiter: RTL and testbench

Two-client round-robin arbiter and sequencer in front of the board `spi_master`. Each client holds a request with its transmit word and bit count; the arbiter serialises requests onto the master's single `request`/`ready` handshake and returns the received word, masked to the transfer width, with a one-cycle `done` pulse. A watchdog frees a client if the master never signals completion. It sits between the CPU-side peripheral logic and `spi_master` on the MAX1000 board.

---
 rtl/spi_arb_pkg.sv | 12 +
 rtl/spi_arbiter.sv | 102 ++++++++++
 tb/tb_spi_arbiter.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: shared widths, FSM states and transfer-mask helper for spi_arbiter
package spi_arb_pkg;
  localparam int SPI_W = 32;
  localparam int NBITS_W = 6;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, RESP, DRAIN} state_t;
  // Low (n+1) bits set; the 33-bit intermediate lets n == 31 fall out naturally.
  function automatic logic [SPI_W-1:0] nbits_mask(input logic [NBITS_W-1:0] n);
    logic [SPI_W:0] m;
    m = (33'd1 << ({1'b0, n} + 7'd1)) - 33'd1;
    return (n == NBITS_W'(31)) ? '1 : m[SPI_W-1:0];
  endfunction
endpackage

// File: rtl/spi_arbiter.sv
// spi_arbiter: two-client round-robin sequencer in front of spi_master
//   clk_in, rst (sync, active-high)
//   cN_req/cN_wdata/cN_nbits   : client N request level, MOSI word, bit count minus one
//   cN_done/cN_rdata/cN_err    : one-cycle completion pulse, masked MISO word, timeout flag
//   busy, grant                : transfer in progress, index of client being served
//   m_request/m_mosi_data/m_nbits/m_miso_data/m_ready : spi_master handshake
module spi_arbiter
  import spi_arb_pkg::*;
#(
  parameter logic [31:0] TIMEOUT = 32'd16777215
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic               c0_req,
  input  logic               c1_req,
  input  logic [SPI_W-1:0]   c0_wdata,
  input  logic [SPI_W-1:0]   c1_wdata,
  input  logic [NBITS_W-1:0] c0_nbits,
  input  logic [NBITS_W-1:0] c1_nbits,
  output logic               c0_done,
  output logic               c1_done,
  output logic [SPI_W-1:0]   c0_rdata,
  output logic [SPI_W-1:0]   c1_rdata,
  output logic               c0_err,
  output logic               c1_err,
  output logic               busy,
  output logic               grant,
  output logic               m_request,
  output logic [SPI_W-1:0]   m_mosi_data,
  output logic [NBITS_W-1:0] m_nbits,
  input  logic [SPI_W-1:0]   m_miso_data,
  input  logic               m_ready
);
  state_t r_state, w_next;
  logic r_last, r_grant, r_done0, r_done1, r_err0, r_err1;
  logic [SPI_W-1:0] r_mosi, r_rdata0, r_rdata1, r_wd;
  logic [NBITS_W-1:0] r_nbits;
  logic w_any, w_pick, w_wait, w_to, w_fin;
  logic [SPI_W-1:0] w_cap;
  assign w_any  = c0_req | c1_req;
  // Tie goes to the client not served last; a lone requester always wins.
  assign w_pick = (c0_req & c1_req) ? ~r_last : c1_req;
  assign w_wait = r_state == WAIT_DONE;
  assign w_to   = w_wait & ~m_ready & (r_wd == TIMEOUT);
  assign w_fin  = w_wait & (m_ready | (r_wd == TIMEOUT));
  assign w_cap  = m_ready ? (m_miso_data & nbits_mask(r_nbits)) : '0;
  always_ff @(posedge clk_in)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      w_next = w_any ? ISSUE : IDLE;
      ISSUE:     w_next = WAIT_DONE;
      WAIT_DONE: w_next = m_ready ? RESP : (w_to ? DRAIN : WAIT_DONE);
      RESP:      w_next = IDLE;
      DRAIN:     w_next = m_ready ? IDLE : DRAIN;
      default:   w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_last   <= 1'b1;
      r_grant  <= 1'b0;
      r_mosi   <= '0;
      r_nbits  <= '0;
      r_wd     <= '0;
      r_done0  <= 1'b0;
      r_done1  <= 1'b0;
      r_err0   <= 1'b0;
      r_err1   <= 1'b0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      if (r_state == IDLE && w_any) begin
        r_grant <= w_pick;
        r_last  <= w_pick;
        r_mosi  <= w_pick ? c1_wdata : c0_wdata;
        r_nbits <= w_pick ? c1_nbits : c0_nbits;
      end
      r_wd    <= w_wait ? r_wd + 1'b1 : '0;
      // done/err are registered so they land in RESP or the first DRAIN cycle only.
      r_done0 <= w_fin & ~r_grant;
      r_done1 <= w_fin & r_grant;
      r_err0  <= w_to & ~r_grant;
      r_err1  <= w_to & r_grant;
      if (w_fin & ~r_grant) r_rdata0 <= w_cap;
      if (w_fin & r_grant) r_rdata1 <= w_cap;
    end
  end
  assign busy        = r_state != IDLE;
  assign grant       = r_grant;
  assign m_request   = r_state == ISSUE;
  assign m_mosi_data = r_mosi;
  assign m_nbits     = r_nbits;
  assign c0_done     = r_done0;
  assign c1_done     = r_done1;
  assign c0_err      = r_err0;
  assign c1_err      = r_err1;
  assign c0_rdata    = r_rdata0;
  assign c1_rdata    = r_rdata1;
endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: self-checking bench for spi_arbiter with a behavioural spi_master
module tb_spi_arbiter;
  localparam logic [31:0] TO = 32'd20;
  logic clk_in = 1'b0, rst = 1'b1;
  logic c0_req = 1'b0, c1_req = 1'b0;
  logic [31:0] c0_wdata = '0, c1_wdata = '0;
  logic [5:0] c0_nbits = '0, c1_nbits = '0;
  logic c0_done, c1_done, c0_err, c1_err, busy, grant, m_request;
  logic [31:0] c0_rdata, c1_rdata, m_mosi_data;
  logic [5:0] m_nbits;
  logic [31:0] m_miso_data;
  logic m_ready;

  spi_arbiter #(.TIMEOUT(TO)) dut (
    .clk_in(clk_in), .rst(rst),
    .c0_req(c0_req), .c1_req(c1_req),
    .c0_wdata(c0_wdata), .c1_wdata(c1_wdata),
    .c0_nbits(c0_nbits), .c1_nbits(c1_nbits),
    .c0_done(c0_done), .c1_done(c1_done),
    .c0_rdata(c0_rdata), .c1_rdata(c1_rdata),
    .c0_err(c0_err), .c1_err(c1_err),
    .busy(busy), .grant(grant),
    .m_request(m_request), .m_mosi_data(m_mosi_data), .m_nbits(m_nbits),
    .m_miso_data(m_miso_data), .m_ready(m_ready)
  );

  always #5 clk_in = ~clk_in;

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // Master model: accepts in its idle state, returns miso_val lat+1 cycles later unless hung.
  int lat = 2, mcnt = 0;
  bit hang = 1'b0;
  logic [31:0] miso_val = '0;
  always @(posedge clk_in) begin
    if (rst) begin
      m_ready <= 1'b1;
      m_miso_data <= '0;
      mcnt <= 0;
    end else if (m_request && m_ready) begin
      m_ready <= 1'b0;
      mcnt <= lat;
    end else if (!m_ready && !hang) begin
      if (mcnt == 0) begin
        m_ready <= 1'b1;
        m_miso_data <= miso_val;
      end else mcnt <= mcnt - 1;
    end
  end

  // Record what was presented to the master on each request pulse.
  int req_cnt = 0, req_cyc = 0;
  logic [5:0] req_nbits = '0;
  logic [31:0] req_mosi = '0;
  logic req_grant = 1'b0;
  always @(negedge clk_in)
    if (m_request) begin
      req_cnt <= req_cnt + 1;
      req_cyc <= cyc;
      req_nbits <= m_nbits;
      req_mosi <= m_mosi_data;
      req_grant <= grant;
    end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_done(input int budget, output int who, output int at);
    who = -1;
    for (int i = 0; i < budget && who < 0; i++) begin
      @(negedge clk_in);
      if (c0_done) who = 0;
      else if (c1_done) who = 1;
    end
    at = cyc;
  endtask

  // Expected received word: the low nb+1 bits of v, by modular arithmetic.
  function automatic logic [31:0] ref_rd(input logic [31:0] v, input int nb);
    logic [63:0] m;
    m = 64'd1 << (nb + 1);
    return 32'({32'd0, v} % m);
  endfunction

  task automatic xfer(input string nm, input logic c, input logic [31:0] wd,
                      input logic [5:0] nb, input logic [31:0] mi, input logic [31:0] exp);
    int who, at, n0;
    miso_val = mi;
    n0 = req_cnt;
    if (c) begin c1_wdata = wd; c1_nbits = nb; c1_req = 1'b1; end
    else begin c0_wdata = wd; c0_nbits = nb; c0_req = 1'b1; end
    wait_done(200, who, at);
    chk({nm, " who"}, who, 32'(c));
    chk({nm, " rdata"}, c ? c1_rdata : c0_rdata, exp);
    chk({nm, " err"}, 32'(c ? c1_err : c0_err), 32'd0);
    chk({nm, " reqs"}, req_cnt - n0, 32'd1);
    chk({nm, " nbits"}, 32'(req_nbits), 32'(nb));
    chk({nm, " mosi"}, req_mosi, wd);
    chk({nm, " grant"}, 32'(req_grant), 32'(c));
    if (c) c1_req = 1'b0; else c0_req = 1'b0;
    @(negedge clk_in);
    chk({nm, " pulse"}, 32'(c0_done | c1_done), 32'd0);
  endtask

  typedef struct packed {
    logic c;
    logic [31:0] wd;
    logic [5:0] nb;
    logic [31:0] mi;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[7];

  initial begin
    int who, at, n0, nd, pat, pending, e;
    bit m_last;
    logic [31:0] wd0, wd1, mi;
    logic [5:0] nb0, nb1;
    tbl[0] = '{1'b0, 32'h0000_00A5, 6'd7,  32'hFFFF_FF3C, 32'h0000_003C};
    tbl[1] = '{1'b1, 32'h0000_1234, 6'd31, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    tbl[2] = '{1'b0, 32'h0000_005A, 6'd0,  32'h0000_0003, 32'h0000_0001};
    tbl[3] = '{1'b1, 32'h0000_BEEF, 6'd15, 32'h1234_5678, 32'h0000_5678};
    tbl[4] = '{1'b0, 32'h0000_000F, 6'd3,  32'h0000_00FF, 32'h0000_000F};
    tbl[5] = '{1'b1, 32'h0000_0001, 6'd30, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
    tbl[6] = '{1'b0, 32'h0000_0003, 6'd1,  32'h0000_0006, 32'h0000_0002};

    repeat (3) @(negedge clk_in);
    rst = 1'b0;
    @(negedge clk_in);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst grant", 32'(grant), 32'd0);
    chk("rst m_request", 32'(m_request), 32'd0);
    chk("rst m_mosi", m_mosi_data, 32'd0);
    chk("rst m_nbits", 32'(m_nbits), 32'd0);
    chk("rst done/err", 32'({c0_done, c1_done, c0_err, c1_err}), 32'd0);
    chk("rst c0_rdata", c0_rdata, 32'd0);
    chk("rst c1_rdata", c1_rdata, 32'd0);

    // Both held after reset: grants alternate starting with client 0.
    lat = 1;
    miso_val = 32'hCAFE_BABE;
    c0_wdata = 32'h11; c0_nbits = 6'd7;
    c1_wdata = 32'h22; c1_nbits = 6'd15;
    c0_req = 1'b1; c1_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_done(100, who, at);
      chk("alt who", who, k % 2);
      chk("alt rdata", (k % 2) ? c1_rdata : c0_rdata, (k % 2) ? 32'h0000_BABE : 32'h0000_00BE);
      chk("alt grant", 32'(req_grant), k % 2);
    end
    c0_req = 1'b0; c1_req = 1'b0;
    @(negedge clk_in);

    for (int i = 0; i < 7; i++) begin
      lat = i;
      xfer($sformatf("vec%0d", i), tbl[i].c, tbl[i].wd, tbl[i].nb, tbl[i].mi, tbl[i].exp);
    end

    // Watchdog: master never answers; c1 must wait until ready finally rises.
    hang = 1'b1; lat = 2;
    n0 = req_cnt;
    c0_wdata = 32'h55; c0_nbits = 6'd7; c0_req = 1'b1;
    wait_done(100, who, at);
    chk("to who", who, 32'd0);
    chk("to err", 32'(c0_err), 32'd1);
    chk("to rdata", c0_rdata, 32'd0);
    chk("to latency", at - req_cyc, TO + 32'd2);
    c0_req = 1'b0;
    c1_wdata = 32'h77; c1_nbits = 6'd7; c1_req = 1'b1;
    @(negedge clk_in);
    chk("to err pulse", 32'(c0_err | c0_done), 32'd0);
    repeat (10) @(negedge clk_in);
    chk("to c1 held", req_cnt - n0, 32'd1);
    chk("to drain busy", 32'(busy), 32'd1);
    hang = 1'b0;
    xfer("after to", 1'b1, 32'h77, 6'd7, 32'h1234_5681, 32'h81);

    // Reset while waiting on the master.
    lat = 15;
    n0 = req_cnt;
    c0_wdata = 32'h99; c0_nbits = 6'd7; c0_req = 1'b1;
    for (int i = 0; i < 20 && req_cnt == n0; i++) @(negedge clk_in);
    chk("rst issued", req_cnt - n0, 32'd1);
    repeat (3) @(negedge clk_in);
    rst = 1'b1;
    @(negedge clk_in);
    chk("mid rst busy", 32'(busy), 32'd0);
    chk("mid rst m_request", 32'(m_request), 32'd0);
    chk("mid rst done", 32'(c0_done | c1_done), 32'd0);
    rst = 1'b0; c0_req = 1'b0;
    nd = 0;
    repeat (25) begin @(negedge clk_in); nd += int'(c0_done | c1_done); end
    chk("mid rst no done", nd, 32'd0);
    lat = 3;
    xfer("post rst", 1'b0, 32'hC3, 6'd7, 32'h0000_0A5A, 32'h5A);

    // Client drops req one cycle after grant; transfer still completes once.
    lat = 4;
    miso_val = 32'hFEDC_BA98;
    c1_wdata = 32'h44; c1_nbits = 6'd11; c1_req = 1'b1;
    @(negedge clk_in);
    chk("drop grant", 32'(grant), 32'd1);
    c1_req = 1'b0;
    nd = 0;
    repeat (30) begin @(negedge clk_in); if (c1_done) begin nd++; chk("drop rdata", c1_rdata, 32'h0000_0A98); end end
    chk("drop done count", nd, 32'd1);

    // Random rounds against a served-last model; m_last mirrors the client served most recently.
    m_last = 1'b1;
    for (int r = 0; r < 40; r++) begin
      pat = int'($urandom_range(1, 3));
      wd0 = $urandom; wd1 = $urandom; mi = $urandom;
      nb0 = 6'($urandom_range(0, 31)); nb1 = 6'($urandom_range(0, 31));
      lat = int'($urandom_range(0, 8));
      miso_val = mi;
      c0_wdata = wd0; c0_nbits = nb0; c1_wdata = wd1; c1_nbits = nb1;
      c0_req = pat[0]; c1_req = pat[1];
      pending = pat;
      while (pending != 0) begin
        e = (pending == 3) ? int'(!m_last) : ((pending == 2) ? 1 : 0);
        wait_done(100, who, at);
        chk("rnd who", who, e);
        chk("rnd rdata", e ? c1_rdata : c0_rdata, ref_rd(mi, e ? int'(nb1) : int'(nb0)));
        chk("rnd nbits", 32'(req_nbits), e ? 32'(nb1) : 32'(nb0));
        chk("rnd mosi", req_mosi, e ? wd1 : wd0);
        if (e == 1) c1_req = 1'b0; else c0_req = 1'b0;
        m_last = (e == 1);
        pending = (who < 0) ? 0 : (pending & ~(1 << e));
      end
      c0_req = 1'b0; c1_req = 1'b0;
      @(negedge clk_in);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
